h2a_frame_sched: RTL
====================

// Module: h2a_frame_sched
// PURPOSE
//   Frame scheduler/arbiter in front of the hex-to-ASCII converter on the UART report path.
//   Shares the converter between two requesters (0: temperature report, 1: command echo).
//   Emits one frame per grant: raw header char, DATA_BYTES data bytes sent as hex, then raw CR LF.
//   Drives the converter's din/h2a_en/din_vld inputs and paces bytes with a downstream ready.
// PARAMETERS
//   DATA_BYTES  2      payload bytes per frame (1..4); DATA_W = 8*DATA_BYTES
//   HDR0        8'h54  raw header char for requester 0 ('T')
//   HDR1        8'h43  raw header char for requester 1 ('C')
// PORTS
//   clk       in   1        system clock
//   rst_n     in   1        reset; synchronous, active-low
//   req0      in   1        requester 0 frame request; level, held until gnt0
//   dat0      in   DATA_W   requester 0 payload; sampled in the cycle gnt0 is high
//   gnt0      out  1        one-cycle grant/accept pulse to requester 0
//   req1      in   1        requester 1 frame request; level, held until gnt1
//   dat1      in   DATA_W   requester 1 payload; sampled in the cycle gnt1 is high
//   gnt1      out  1        one-cycle grant/accept pulse to requester 1
//   ds_rdy    in   1        downstream (converter FIFO not almost-full) may take a byte
//   dout      out  8        byte to converter din
//   h2a_en    out  1        1 = convert byte to two hex chars, 0 = pass raw
//   dout_vld  out  1        byte strobe to converter din_vld
//   busy      out  1        high whenever state != IDLE
// BEHAVIOUR
//   - Reset: state=IDLE; dout=0, h2a_en=0, dout_vld=0, gnt0=gnt1=0, busy=0, byte counter=0,
//     RR pointer=0. Reset mid-frame aborts the frame; no further bytes are emitted.
//   - FSM: IDLE -> GRANT -> HDR -> DATA -> CR -> LF -> IDLE.
//   - IDLE: if any req, pick winner (arbitration below), go to GRANT. No req: stay.
//   - GRANT (1 cycle): gntX=1 for the winner only; capture datX and the winner id; go to HDR.
//   - Emitting states (HDR/DATA/CR/LF): byte issued only in a cycle with ds_rdy=1; the registered
//     outputs dout/h2a_en/dout_vld update at the next edge (dout_vld one cycle wide per byte).
//     ds_rdy=0 holds state, dout_vld=0, dout/h2a_en keep last value.
//   - HDR: dout=HDR0/HDR1 per winner, h2a_en=0.
//   - DATA: payload MSB byte first, h2a_en=1; counter 0..DATA_BYTES-1, end at DATA_BYTES-1 -> CR.
//   - CR: dout=8'h0D, h2a_en=0. LF: dout=8'h0A, h2a_en=0 -> IDLE.
//   - Throughput: with ds_rdy held high, frame bytes are issued on consecutive cycles;
//     min 2 cycles (IDLE+GRANT) between last LF strobe and next HDR issue.
//   - Latency: req high at IDLE edge N -> gnt high cycle N+1 -> HDR dout_vld at cycle N+3 (ds_rdy=1).
//   - Requests arriving while busy wait; req dropped before grant is ignored (no frame).
//   - Payload changes after grant do not affect the frame in flight.
// CONFIGURATION
//   H2A_RR_ARB_EN defined: round-robin; on a tie the requester not served last wins; pointer
//     flips to the other requester after each grant.
//   Not defined: fixed priority, req0 always wins a tie; pointer logic absent.
//   Single requests are granted identically in both builds.
// TESTING
//   1. req0=1, dat0=16'h1A2F, ds_rdy=1 -> bytes 54(en0),1A(en1),2F(en1),0D,0A on 5 consecutive
//      cycles; gnt0 one pulse; converter output "T1A2F\r\n".
//   2. req1=1, dat1=16'h00FF, ds_rdy toggles 1/0 each cycle -> bytes 43,00,FF,0D,0A, one per
//      ds_rdy=1 cycle, no strobe while ds_rdy=0, busy high until after LF.
//   3. req0=req1=1 held for 3 frames -> RR build: gnt order 0,1,0; fixed build: 0,0,0.
//   4. Assert rst_n=0 for one cycle after DATA byte 1 -> next cycle all outputs 0, state IDLE,
//      no CR/LF emitted; held req0 then gets a fresh full frame.
//   5. req1 pulses 1 cycle while frame 0 is in flight, drops before IDLE -> no gnt1, no frame.
//   6. dat0 changed to 16'hBEEF one cycle after gnt0 with original 16'h1234 -> frame carries 12,34.

Source files
------------

// File: rtl/h2a_frame_sched.sv
// Frame scheduler/arbiter sharing the hex-to-ASCII converter between two requesters.
// Define H2A_RR_ARB_EN for round-robin arbitration; otherwise requester 0 wins ties.
module h2a_frame_sched #(
  parameter int unsigned DATA_BYTES = 2,
  parameter logic [7:0]  HDR0       = 8'h54,
  parameter logic [7:0]  HDR1       = 8'h43,
  localparam int unsigned DATA_W    = 8 * DATA_BYTES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic [DATA_W-1:0] dat0,
  output logic              gnt0,
  input  logic              req1,
  input  logic [DATA_W-1:0] dat1,
  output logic              gnt1,
  input  logic              ds_rdy,
  output logic [7:0]        dout,
  output logic              h2a_en,
  output logic              dout_vld,
  output logic              busy
);

  typedef enum logic [2:0] {StIdle, StGrant, StHdr, StData, StCr, StLf} state_e;

  localparam logic [1:0] LastCnt = 2'(DATA_BYTES - 1);

  state_e            state_q, state_d;
  logic              win_q, win_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [7:0]        dout_q, dout_d;
  logic              en_q, en_d;
  logic              vld_q, vld_d;
  logic              pick;

`ifdef H2A_RR_ARB_EN
  logic ptr_q, ptr_d;

  // On a tie the pointer names the preferred requester.
  assign pick = (req0 && req1) ? ptr_q : req1;

  always_ff @(posedge clk) begin
    if (!rst_n) ptr_q <= 1'b0;
    else        ptr_q <= ptr_d;
  end
`else
  assign pick = req1 && !req0;
`endif

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    en_d    = en_q;
    vld_d   = 1'b0;
    gnt0    = 1'b0;
    gnt1    = 1'b0;
`ifdef H2A_RR_ARB_EN
    ptr_d   = ptr_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (req0 || req1) begin
          win_d   = pick;
          state_d = StGrant;
        end
      end
      StGrant: begin
        gnt0    = !win_q;
        gnt1    = win_q;
        data_d  = win_q ? dat1 : dat0;
        cnt_d   = 2'd0;
`ifdef H2A_RR_ARB_EN
        ptr_d   = !win_q;
`endif
        state_d = StHdr;
      end
      StHdr: begin
        if (ds_rdy) begin
          dout_d  = win_q ? HDR1 : HDR0;
          en_d    = 1'b0;
          vld_d   = 1'b1;
          state_d = StData;
        end
      end
      StData: begin
        if (ds_rdy) begin
          // Payload goes out MSB byte first; shift the next byte into the top slot.
          dout_d = data_q[DATA_W-1 -: 8];
          en_d   = 1'b1;
          vld_d  = 1'b1;
          data_d = data_q << 8;
          if (cnt_q == LastCnt) state_d = StCr;
          else                  cnt_d   = cnt_q + 2'd1;
        end
      end
      StCr: begin
        if (ds_rdy) begin
          dout_d  = 8'h0D;
          en_d    = 1'b0;
          vld_d   = 1'b1;
          state_d = StLf;
        end
      end
      StLf: begin
        if (ds_rdy) begin
          dout_d  = 8'h0A;
          en_d    = 1'b0;
          vld_d   = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      win_q   <= 1'b0;
      data_q  <= '0;
      cnt_q   <= 2'd0;
      dout_q  <= 8'h00;
      en_q    <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      en_q    <= en_d;
      vld_q   <= vld_d;
    end
  end

  assign dout     = dout_q;
  assign h2a_en   = en_q;
  assign dout_vld = vld_q;
  assign busy     = (state_q != StIdle);

endmodule
